// File: rtl/game_tick_scheduler.sv
`timescale 1ns/1ps
// Purpose : game run-state FSM plus phase-accumulator tick enables (scroll/anim/score), score and speed level.
// Latency : all outputs registered; state changes one edge after the input pulse, ticks one edge after accumulator wrap.
// Backpressure: none; inputs are single-cycle pulses, ticks are one-cycle enables gated to the RUN state.
//
// Ports:
//   clk, rst_n           - system clock, asynchronous active-low reset
//   start, pause, crash  - one-cycle control pulses
//   state                - 00 IDLE, 01 RUN, 10 PAUSED, 11 OVER
//   scroll_tick, anim_tick, score_tick - one-cycle enables
//   level                - speed level (saturates at MAX_LEVEL)
//   score                - binary score (saturates at 0xFFFF)
module game_tick_scheduler #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned SCROLL_BASE_HZ = 100,
  parameter int unsigned SCROLL_STEP_HZ = 20,
  parameter int unsigned ANIM_HZ        = 10,
  parameter int unsigned SCORE_HZ       = 10,
  parameter int unsigned LEVEL_UP_SCORE = 100,
  parameter int unsigned MAX_LEVEL      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        pause,
  input  logic        crash,
  output logic [1:0]  state,
  output logic        scroll_tick,
  output logic        anim_tick,
  output logic        score_tick,
  output logic [3:0]  level,
  output logic [15:0] score
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10,
    ST_OVER   = 2'b11
  } state_e;

  localparam logic [32:0] CLK_W = 33'(CLK_HZ);
  localparam int SUB_W = (LEVEL_UP_SCORE > 1) ? $clog2(LEVEL_UP_SCORE) : 1;

  state_e          state_q, state_d;
  logic            restart;
  logic [31:0]     scroll_acc_q, scroll_acc_d;
  logic [31:0]     anim_acc_q, anim_acc_d;
  logic [31:0]     score_acc_q, score_acc_d;
  logic            scroll_tick_q, scroll_tick_d;
  logic            anim_tick_q, anim_tick_d;
  logic            score_tick_q, score_tick_d;
  logic [3:0]      level_q, level_d;
  logic [15:0]     score_q, score_d;
  logic [SUB_W-1:0] sub_q, sub_d;

  logic [31:0]     scroll_rate;
  logic [32:0]     scroll_step, anim_step, score_step;

  // One accumulate step: bit 32 is the wrap (tick) flag, bits 31:0 the new phase.
  // CLK_HZ + rate fits in 32 bits, so the 33-bit sum never loses a carry.
  function automatic logic [32:0] acc_step(input logic [31:0] acc, input logic [31:0] rate);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, rate};
    if (sum >= CLK_W) acc_step = {1'b1, sum[31:0] - CLK_W[31:0]};
    else              acc_step = {1'b0, sum[31:0]};
  endfunction

  // Rate uses the registered level, so a level-up takes effect on the following edge.
  assign scroll_rate = 32'(SCROLL_BASE_HZ) + 32'(level_q) * 32'(SCROLL_STEP_HZ);
  assign scroll_step = acc_step(scroll_acc_q, scroll_rate);
  assign anim_step   = acc_step(anim_acc_q, 32'(ANIM_HZ));
  assign score_step  = acc_step(score_acc_q, 32'(SCORE_HZ));

  // Run-state FSM; crash wins over pause in RUN.
  always_comb begin
    state_d = state_q;
    restart = 1'b0;
    case (state_q)
      ST_IDLE:   if (start) begin state_d = ST_RUN; restart = 1'b1; end
      ST_RUN:    if (crash) state_d = ST_OVER;
                 else if (pause) state_d = ST_PAUSED;
      ST_PAUSED: if (pause) state_d = ST_RUN;
      ST_OVER:   if (start) begin state_d = ST_RUN; restart = 1'b1; end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    scroll_acc_d  = scroll_acc_q;
    anim_acc_d    = anim_acc_q;
    score_acc_d   = score_acc_q;
    scroll_tick_d = 1'b0;
    anim_tick_d   = 1'b0;
    score_tick_d  = 1'b0;
    level_d       = level_q;
    score_d       = score_q;
    sub_d         = sub_q;

    if (restart) begin
      scroll_acc_d = '0;
      anim_acc_d   = '0;
      score_acc_d  = '0;
      level_d      = '0;
      score_d      = '0;
      sub_d        = '0;
    end else begin
      if (state_q == ST_RUN) begin
        scroll_acc_d = scroll_step[31:0];
        anim_acc_d   = anim_step[31:0];
        score_acc_d  = score_step[31:0];
        // The phase still advances on the leaving edge, but no tick is shown
        // outside RUN.
        scroll_tick_d = scroll_step[32] && (state_d == ST_RUN);
        anim_tick_d   = anim_step[32]   && (state_d == ST_RUN);
        score_tick_d  = score_step[32]  && (state_d == ST_RUN);
      end
      if (score_tick_q) begin
        if (score_q != 16'hFFFF) score_d = score_q + 16'd1;
        if (sub_q == SUB_W'(LEVEL_UP_SCORE - 1)) begin
          sub_d = '0;
          if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
        end else begin
          sub_d = sub_q + SUB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      scroll_acc_q  <= '0;
      anim_acc_q    <= '0;
      score_acc_q   <= '0;
      scroll_tick_q <= 1'b0;
      anim_tick_q   <= 1'b0;
      score_tick_q  <= 1'b0;
      level_q       <= '0;
      score_q       <= '0;
      sub_q         <= '0;
    end else begin
      state_q       <= state_d;
      scroll_acc_q  <= scroll_acc_d;
      anim_acc_q    <= anim_acc_d;
      score_acc_q   <= score_acc_d;
      scroll_tick_q <= scroll_tick_d;
      anim_tick_q   <= anim_tick_d;
      score_tick_q  <= score_tick_d;
      level_q       <= level_d;
      score_q       <= score_d;
      sub_q         <= sub_d;
    end
  end

  assign state       = state_q;
  assign scroll_tick = scroll_tick_q;
  assign anim_tick   = anim_tick_q;
  assign score_tick  = score_tick_q;
  assign level       = level_q;
  assign score       = score_q;

endmodule
